// File: rtl/pixel_pkg.sv
// Shared types and defaults for the raster-order pixel reassembly path.
package pixel_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_RBG_SIZE      = 24;
    localparam int DEF_NUM_ENGINES   = 4;
    localparam int DEF_SCREEN_WIDTH  = 640;
    localparam int DEF_SCREEN_HEIGHT = 480;

    // x value broadcast when no pixel is being requested: one past the last
    // column, so no engine ever produces it and it differs from the queues'
    // all-ones empty entries.
    localparam int DEF_SENTINEL = DEF_SCREEN_WIDTH;

    typedef logic [DEF_RBG_SIZE-1:0] colour_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OUT
    } comb_state_t;

    // Counter width for a screen dimension; never narrower than one bit.
    function automatic int coord_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order (x, y) coordinate generator: clear to (0,0), advance one pixel.
module raster_counter
    import pixel_pkg::*;
#(
    parameter int  SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int  SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    localparam int XW            = coord_width(SCREEN_WIDTH),
    localparam int YW            = coord_width(SCREEN_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_in_line,
    output logic          last_in_frame
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign last_in_line  = (x_q == XW'(SCREEN_WIDTH - 1));
    assign last_in_frame = last_in_line && (y_q == YW'(SCREEN_HEIGHT - 1));
    assign x = x_q;
    assign y = y_q;

    // Next coordinate: clear wins, otherwise step x and wrap into the next line.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (last_in_line) begin
                x_d = '0;
                y_d = last_in_frame ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pixel_combinator.sv
// Requests pixels from the engine reorder queues in raster order and streams
// them out on a valid/ready interface with start-of-frame / end-of-line marks.
module pixel_combinator
    import pixel_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int RBG_SIZE      = DEF_RBG_SIZE,
    parameter int NUM_ENGINES   = DEF_NUM_ENGINES,
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    output logic [DATA_WIDTH-1:0]         xpixel_check,
    output logic [DATA_WIDTH-1:0]         ypixel_check,
    input  logic [NUM_ENGINES-1:0]        hit_i,
    input  logic [NUM_ENGINES*RBG_SIZE-1:0] colour_i,
    output logic [RBG_SIZE-1:0]           pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_sof,
    output logic                          pix_eol,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          err_multi_hit
);

    localparam int XW = coord_width(SCREEN_WIDTH);
    localparam int YW = coord_width(SCREEN_HEIGHT);
    localparam logic [DATA_WIDTH-1:0] SENTINEL = DATA_WIDTH'(SCREEN_WIDTH);

    comb_state_t           state_q, state_d;
    logic [RBG_SIZE-1:0]   pix_data_q, pix_data_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  pix_sof_q, pix_sof_d;
    logic                  pix_eol_q, pix_eol_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_q, err_d;

    logic                  cnt_clear, cnt_advance;
    logic [XW-1:0]         cur_x;
    logic [YW-1:0]         cur_y;
    logic                  last_in_line, last_in_frame;

    logic [RBG_SIZE-1:0]   colour_slice [NUM_ENGINES];
    logic [RBG_SIZE-1:0]   sel_colour;
    logic                  sel_found;
    logic                  hit_any, hit_multi;

    raster_counter #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_raster (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (cnt_clear),
        .advance      (cnt_advance),
        .x            (cur_x),
        .y            (cur_y),
        .last_in_line (last_in_line),
        .last_in_frame(last_in_frame)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENGINES; gi++) begin : g_slice
            assign colour_slice[gi] = colour_i[gi*RBG_SIZE +: RBG_SIZE];
        end
    endgenerate

    assign hit_any   = |hit_i;
    assign hit_multi = ($countones(hit_i) > 1);

    // Lowest-index hit wins when several queues answer at once.
    always_comb begin
        sel_colour = '0;
        sel_found  = 1'b0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (hit_i[k] && !sel_found) begin
                sel_colour = colour_slice[k];
                sel_found  = 1'b1;
            end
        end
    end

    // Coordinates are only broadcast in WAIT; otherwise the sentinel keeps a
    // queue from matching (and popping) a second time.
    assign xpixel_check = (state_q == WAIT) ? DATA_WIDTH'(cur_x) : SENTINEL;
    assign ypixel_check = (state_q == WAIT) ? DATA_WIDTH'(cur_y) : '0;

    assign pix_data      = pix_data_q;
    assign pix_valid     = pix_valid_q;
    assign pix_sof       = pix_sof_q;
    assign pix_eol       = pix_eol_q;
    assign frame_done    = frame_done_q;
    assign err_multi_hit = err_q;
    assign busy          = (state_q != IDLE);

    // Next-state and output-register computation for the request/emit FSM.
    always_comb begin
        state_d      = state_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = pix_valid_q;
        pix_sof_d    = pix_sof_q;
        pix_eol_d    = pix_eol_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        cnt_clear    = 1'b0;
        cnt_advance  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit_any) err_d = 1'b1;
                if (start) begin
                    cnt_clear = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (hit_any) begin
                    pix_data_d  = sel_colour;
                    pix_valid_d = 1'b1;
                    pix_sof_d   = (cur_x == '0) && (cur_y == '0);
                    pix_eol_d   = last_in_line;
                    state_d     = OUT;
                    if (hit_multi) err_d = 1'b1;
                end
            end
            OUT: begin
                if (hit_any) err_d = 1'b1;
                if (pix_valid_q && pix_ready) begin
                    pix_valid_d = 1'b0;
                    pix_sof_d   = 1'b0;
                    pix_eol_d   = 1'b0;
                    if (last_in_frame) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        cnt_advance = 1'b1;
                        state_d     = WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_sof_q    <= pix_sof_d;
            pix_eol_q    <= pix_eol_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

endmodule
